// File: rtl/hazard_pkg.sv
// ---------------------------------------------------------------------------
// hazard_pkg
// Shared types and constants for the pipeline stall/flush controller.
//   state_e   : load-use FSM states
//   REG_ZERO  : index of the hard-wired zero register (never a real hazard)
//   cnt_width : width needed to hold a countdown start value (minimum 1)
// ---------------------------------------------------------------------------
package hazard_pkg;

    typedef enum logic {
        IDLE     = 1'b0,
        LD_STALL = 1'b1
    } state_e;

    localparam int unsigned REG_ZERO = 0;

    // Bits needed to represent the value v; never less than one bit.
    function automatic int unsigned cnt_width(input int unsigned v);
        return (v < 2) ? 1 : $clog2(v + 1);
    endfunction

endpackage

// File: rtl/hz_countdown.sv
// ---------------------------------------------------------------------------
// hz_countdown
// Loadable down-counter used for the load-use bubble count and the
// mult/div busy window. A load wins over a decrement; a decrement only
// takes effect while the count is nonzero, so the counter parks at zero.
// Ports:
//   clk        in   core clock
//   rst        in   asynchronous, active-high reset (count -> 0)
//   load_i     in   load load_val_i on the next edge
//   load_val_i in   W   value to load
//   dec_i      in   decrement by one on the next edge (when nonzero)
//   count_o    out  W   current count
//   zero_o     out  count_o == 0
// ---------------------------------------------------------------------------
module hz_countdown #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic [W-1:0] count_o,
    output logic         zero_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // NOTE: combinational blocks assign every output a default first so no
    // path through the block leaves a value unassigned (which would infer a latch).
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (dec_i && (count_q != '0)) begin
            count_d = count_q - W'(1);
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples its inputs from before the clock edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign zero_o  = (count_q == '0);

endmodule

// File: rtl/hazard_stall_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_stall_ctrl
// Stall/flush controller for the 5-stage MIPS pipeline, sitting beside ID.
// Detects load-use hazards (stalling LOAD_LAT cycles per hazard), interlocks
// mfhi/mflo against a busy multi-cycle mult/div unit, flushes IF/ID on a
// taken branch or jump, and counts stalled cycles (saturating).
// All control outputs are combinational: a hazard stalls in the same cycle.
// Ports:
//   clk           in   core clock
//   rst           in   asynchronous, active-high reset
//   id_rs/id_rt   in   REG_AW  source registers of the ID instruction
//   id_use_rs     in   ID instruction reads rs
//   id_use_rt     in   ID instruction reads rt
//   id_use_md     in   ID instruction reads HI/LO
//   ex_rt         in   REG_AW  load destination held in ID/EX
//   ex_memread    in   ID/EX holds a load
//   md_start      in   mult/div issues in EX this cycle
//   branch_taken  in   ID resolved a taken beq/bne
//   jmp           in   ID holds j/jal/jr
//   pc_write      out  PC may update
//   if_id_write   out  IF/ID may load
//   ctrl_en       out  pass ID control to ID/EX (0 = bubble)
//   if_id_flush   out  zero IF/ID on the next edge
//   stall         out  any stall active this cycle
//   stall_cycles  out  CNT_W  saturating count of stalled cycles
// ---------------------------------------------------------------------------
module hazard_stall_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned REG_AW   = 5,
    parameter int unsigned LOAD_LAT = 1,
    parameter int unsigned MD_LAT   = 4,
    parameter int unsigned CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_use_rs,
    input  logic              id_use_rt,
    input  logic              id_use_md,
    input  logic [REG_AW-1:0] ex_rt,
    input  logic              ex_memread,
    input  logic              md_start,
    input  logic              branch_taken,
    input  logic              jmp,
    output logic              pc_write,
    output logic              if_id_write,
    output logic              ctrl_en,
    output logic              if_id_flush,
    output logic              stall,
    output logic [CNT_W-1:0]  stall_cycles
);

    localparam int unsigned LD_W = cnt_width(LOAD_LAT - 1);
    localparam int unsigned MD_W = cnt_width(MD_LAT);

    // -----------------------------------------------------------------------
    // Hazard detection
    // -----------------------------------------------------------------------
    logic ld_hit;
    logic md_hit;

    // A load into $zero never produces a value, so it cannot cause a hazard.
    assign ld_hit = ex_memread
                  && (ex_rt != REG_AW'(REG_ZERO))
                  && (((ex_rt == id_rs) && id_use_rs) ||
                      ((ex_rt == id_rt) && id_use_rt));

    // -----------------------------------------------------------------------
    // Load-use FSM and its bubble counter
    // -----------------------------------------------------------------------
    state_e          state_q;
    state_e          state_d;
    logic            ld_load;
    logic            ld_dec;
    logic            ld_stall;
    logic [LD_W-1:0] ld_cnt;
    logic            ld_zero;

    always_comb begin
        state_d  = state_q;
        ld_load  = 1'b0;
        ld_dec   = 1'b0;
        ld_stall = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (ld_hit) begin
                    ld_stall = 1'b1;
                    // The first bubble is this cycle; the remaining
                    // LOAD_LAT-1 are served from LD_STALL.
                    if (LOAD_LAT > 1) begin
                        state_d = LD_STALL;
                        ld_load = 1'b1;
                    end
                end
            end
            LD_STALL: begin
                // ID/EX now holds a bubble, so the hazard inputs are ignored.
                ld_stall = 1'b1;
                ld_dec   = 1'b1;
                // Leaving on a zero count too keeps the FSM from sticking if
                // the counter were ever found empty here.
                if ((ld_cnt == LD_W'(1)) || ld_zero) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    hz_countdown #(
        .W (LD_W)
    ) u_ld_cnt (
        .clk        (clk),
        .rst        (rst),
        .load_i     (ld_load),
        .load_val_i (LD_W'(LOAD_LAT - 1)),
        .dec_i      (ld_dec),
        .count_o    (ld_cnt),
        .zero_o     (ld_zero)
    );

    // -----------------------------------------------------------------------
    // Mult/div busy window
    // -----------------------------------------------------------------------
    logic [MD_W-1:0] md_cnt;
    logic            md_zero;

    // A new md_start restarts the window even while already busy. The
    // counter itself stops at zero, so it can decrement unconditionally.
    hz_countdown #(
        .W (MD_W)
    ) u_md_cnt (
        .clk        (clk),
        .rst        (rst),
        .load_i     (md_start),
        .load_val_i (MD_W'(MD_LAT)),
        .dec_i      (1'b1),
        .count_o    (md_cnt),
        .zero_o     (md_zero)
    );

    // The cycle md_start issues, the counter still reads the old value,
    // so a fresh issue does not stall its own cycle.
    assign md_hit = id_use_md && !md_zero;

    // -----------------------------------------------------------------------
    // Control outputs
    // -----------------------------------------------------------------------
    // Reset forces pass-through values even while hazard inputs are active.
    assign stall       = !rst && (ld_stall || md_hit);
    assign pc_write    = !stall;
    assign if_id_write = !stall;
    assign ctrl_en     = !stall;
    // Branch operands are unresolved while stalled, so stall beats flush.
    assign if_id_flush = !rst && (branch_taken || jmp) && !stall;

    // -----------------------------------------------------------------------
    // Saturating stall-cycle counter
    // -----------------------------------------------------------------------
    logic [CNT_W-1:0] stall_cycles_q;
    logic [CNT_W-1:0] stall_cycles_d;

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (stall && (stall_cycles_q != '1)) begin
            stall_cycles_d = stall_cycles_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles_q <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hazard_stall_ctrl
// Directed bench for hazard_stall_ctrl. Two instances share one stimulus:
//   dut_a : LOAD_LAT=1, MD_LAT=4, CNT_W=16
//   dut_b : LOAD_LAT=3, MD_LAT=4, CNT_W=4 (small counter to reach saturation)
// Inputs change 1 ns after a rising edge; outputs are sampled 1 ns later.
// ---------------------------------------------------------------------------
module tb_hazard_stall_ctrl;

    logic       clk;
    logic       rst;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       id_use_rs;
    logic       id_use_rt;
    logic       id_use_md;
    logic [4:0] ex_rt;
    logic       ex_memread;
    logic       md_start;
    logic       branch_taken;
    logic       jmp;

    logic        a_pc_write, a_if_id_write, a_ctrl_en, a_if_id_flush, a_stall;
    logic [15:0] a_stall_cycles;
    logic        b_pc_write, b_if_id_write, b_ctrl_en, b_if_id_flush, b_stall;
    logic [3:0]  b_stall_cycles;

    int n_vec = 0;
    int n_err = 0;

    hazard_stall_ctrl #(
        .REG_AW   (5),
        .LOAD_LAT (1),
        .MD_LAT   (4),
        .CNT_W    (16)
    ) dut_a (
        .clk          (clk),
        .rst          (rst),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_use_rs    (id_use_rs),
        .id_use_rt    (id_use_rt),
        .id_use_md    (id_use_md),
        .ex_rt        (ex_rt),
        .ex_memread   (ex_memread),
        .md_start     (md_start),
        .branch_taken (branch_taken),
        .jmp          (jmp),
        .pc_write     (a_pc_write),
        .if_id_write  (a_if_id_write),
        .ctrl_en      (a_ctrl_en),
        .if_id_flush  (a_if_id_flush),
        .stall        (a_stall),
        .stall_cycles (a_stall_cycles)
    );

    hazard_stall_ctrl #(
        .REG_AW   (5),
        .LOAD_LAT (3),
        .MD_LAT   (4),
        .CNT_W    (4)
    ) dut_b (
        .clk          (clk),
        .rst          (rst),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_use_rs    (id_use_rs),
        .id_use_rt    (id_use_rt),
        .id_use_md    (id_use_md),
        .ex_rt        (ex_rt),
        .ex_memread   (ex_memread),
        .md_start     (md_start),
        .branch_taken (branch_taken),
        .jmp          (jmp),
        .pc_write     (b_pc_write),
        .if_id_write  (b_if_id_write),
        .ctrl_en      (b_ctrl_en),
        .if_id_flush  (b_if_id_flush),
        .stall        (b_stall),
        .stall_cycles (b_stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        id_rs        = '0;
        id_rt        = '0;
        id_use_rs    = 1'b0;
        id_use_rt    = 1'b0;
        id_use_md    = 1'b0;
        ex_rt        = '0;
        ex_memread   = 1'b0;
        md_start     = 1'b0;
        branch_taken = 1'b0;
        jmp          = 1'b0;
    endtask

    // Load into r8 followed by a consumer reading r8 as rs.
    task automatic set_load_hit();
        ex_memread = 1'b1;
        ex_rt      = 5'd8;
        id_rs      = 5'd8;
        id_use_rs  = 1'b1;
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();

        // ---------------- reset state ----------------
        #2;
        check("rst_a_pc_write",    a_pc_write,     1);
        check("rst_a_if_id_write", a_if_id_write,  1);
        check("rst_a_ctrl_en",     a_ctrl_en,      1);
        check("rst_a_flush",       a_if_id_flush,  0);
        check("rst_a_stall",       a_stall,        0);
        check("rst_a_cycles",      a_stall_cycles, 0);
        check("rst_b_cycles",      b_stall_cycles, 0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        // ---------------- 1/2: load-use, LOAD_LAT=1 and 3 ----------------
        set_load_hit();
        #1;
        check("lu_a_stall",       a_stall,        1);
        check("lu_a_pc_write",    a_pc_write,     0);
        check("lu_a_if_id_write", a_if_id_write,  0);
        check("lu_a_ctrl_en",     a_ctrl_en,      0);
        check("lu_b_stall_c1",    b_stall,        1);
        check("lu_a_cycles_c1",   a_stall_cycles, 0);
        tick();
        clear_inputs();   // ID/EX now holds the bubble
        #1;
        check("lu_a_release",     a_stall,        0);
        check("lu_a_pc_write2",   a_pc_write,     1);
        check("lu_a_cycles",      a_stall_cycles, 1);
        check("lu_b_stall_c2",    b_stall,        1);
        check("lu_b_ctrl_en_c2",  b_ctrl_en,      0);
        tick();
        #1;
        check("lu_b_stall_c3",    b_stall,        1);
        tick();
        #1;
        check("lu_b_release",     b_stall,        0);
        check("lu_b_pc_write",    b_pc_write,     1);
        check("lu_b_cycles",      b_stall_cycles, 3);

        // ---------------- 3: non-hazards ----------------
        ex_memread = 1'b1;
        ex_rt      = 5'd0;
        id_rs      = 5'd0;
        id_use_rs  = 1'b1;
        #1;
        check("nz_a_stall_r0",    a_stall,        0);
        check("nz_b_stall_r0",    b_stall,        0);
        ex_rt      = 5'd8;
        id_rs      = 5'd3;
        id_rt      = 5'd8;
        id_use_rt  = 1'b0;
        #1;
        check("nz_a_stall_nort",  a_stall,        0);
        check("nz_b_stall_nort",  b_stall,        0);
        id_use_rt  = 1'b1;
        #1;
        check("lu_a_stall_rt",    a_stall,        1);
        tick();
        clear_inputs();
        tick();
        tick();
        #1;
        check("lu_b_rt_release",  b_stall,        0);
        check("lu_a_cycles2",     a_stall_cycles, 2);
        check("lu_b_cycles2",     b_stall_cycles, 6);

        // ---------------- 4: mult/div interlock ----------------
        // Single issue: busy cycles 1-4, released at 5.
        md_start  = 1'b1;
        id_use_md = 1'b1;
        #1;
        check("md_same_cycle",    a_stall,        0);
        tick();
        md_start = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            #1;
            check($sformatf("md1_a_c%0d", c), a_stall, (c <= 4) ? 1 : 0);
            check($sformatf("md1_b_c%0d", c), b_stall, (c <= 4) ? 1 : 0);
            tick();
        end
        // Restart at cycle 2 extends the stall through cycle 6.
        md_start = 1'b1;
        #1;
        check("md2_a_c0",         a_stall,        0);
        tick();
        md_start = 1'b0;
        #1;
        check("md2_a_c1",         a_stall,        1);
        tick();
        md_start = 1'b1;
        #1;
        check("md2_a_c2",         a_stall,        1);
        tick();
        md_start = 1'b0;
        for (int c = 3; c <= 7; c++) begin
            #1;
            check($sformatf("md2_a_c%0d", c), a_stall, (c <= 6) ? 1 : 0);
            tick();
        end
        id_use_md = 1'b0;
        #1;
        check("md_a_cycles",      a_stall_cycles, 12);
        check("md_b_cycles_sat",  b_stall_cycles, 15);

        // ---------------- 5: branch / jump flush ----------------
        branch_taken = 1'b1;
        #1;
        check("br_a_flush",       a_if_id_flush,  1);
        check("br_a_stall",       a_stall,        0);
        tick();
        branch_taken = 1'b0;
        jmp          = 1'b1;
        #1;
        check("jmp_a_flush",      a_if_id_flush,  1);
        jmp = 1'b0;
        #1;
        check("noflush_a",        a_if_id_flush,  0);
        branch_taken = 1'b1;
        set_load_hit();
        #1;
        check("br_lu_a_flush",    a_if_id_flush,  0);
        check("br_lu_a_stall",    a_stall,        1);
        check("br_lu_b_flush",    b_if_id_flush,  0);
        tick();
        clear_inputs();
        tick();
        tick();
        tick();
        #1;
        check("br_a_cycles",      a_stall_cycles, 13);

        // ---------------- 6: reset during LD_STALL ----------------
        set_load_hit();
        tick();
        clear_inputs();
        #1;
        check("rs_b_in_ldstall",  b_stall,        1);
        rst = 1'b1;
        #1;
        check("rs_b_stall",       b_stall,        0);
        check("rs_b_pc_write",    b_pc_write,     1);
        check("rs_b_if_id_write", b_if_id_write,  1);
        check("rs_b_ctrl_en",     b_ctrl_en,      1);
        check("rs_b_flush",       b_if_id_flush,  0);
        check("rs_b_cycles",      b_stall_cycles, 0);
        check("rs_a_cycles",      a_stall_cycles, 0);
        set_load_hit();
        branch_taken = 1'b1;
        #1;
        check("rs_hit_b_stall",   b_stall,        0);
        check("rs_hit_a_stall",   a_stall,        0);
        check("rs_hit_b_flush",   b_if_id_flush,  0);
        tick();
        clear_inputs();
        rst = 1'b0;
        #1;
        check("rs_b_idle_after",  b_stall,        0);
        tick();

        // ---------------- counter saturation ----------------
        // Back-to-back load-use hazards keep both instances stalled.
        set_load_hit();
        for (int i = 0; i < 20; i++) begin
            #1;
            check($sformatf("sat_b_stall_%0d", i), b_stall, 1);
            check($sformatf("sat_b_cnt_%0d", i), b_stall_cycles, (i < 15) ? i : 15);
            tick();
        end
        clear_inputs();
        #1;
        check("sat_b_final",      b_stall_cycles, 15);
        check("sat_a_final",      a_stall_cycles, 20);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
